// File: rtl/case_7_prod_accum.sv
// ============================================================================
// Module      : case_7_prod_accum
// Description : Saturating signed accumulator for the case_7 MAC product stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module case_7_prod_accum #(
    parameter int PROD_WIDTH = 15,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  len,
    input  logic [PROD_WIDTH-1:0] prod_din,
    input  logic                  prod_vld,
    output logic                  prod_rdy,
    output logic [ACC_WIDTH-1:0]  acc_dout,
    output logic                  acc_vld,
    input  logic                  acc_ack,
    output logic                  busy,
    output logic                  ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_len;
    logic                   r_ovf;

    logic                   w_start_acc;
    logic                   w_xfer;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic [ACC_WIDTH:0]     w_acc_ext;
    logic [ACC_WIDTH:0]     w_prod_ext;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_sat;
    logic [ACC_WIDTH-1:0]   w_acc_sat;

    // One guard bit: disagreement between the top two sum bits means the
    // true result left the ACC_WIDTH range, and the guard bit gives its sign.
    assign w_acc_ext  = {r_acc[ACC_WIDTH-1], r_acc};
    assign w_prod_ext = {{(ACC_WIDTH+1-PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din};
    assign w_sum      = w_acc_ext + w_prod_ext;
    assign w_sat      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_acc_sat  = !w_sat             ? w_sum[ACC_WIDTH-1:0] :
                        w_sum[ACC_WIDTH]   ? c_acc_min : c_acc_max;

    // cnt < len whenever a transfer can happen, so the increment never wraps.
    assign w_cnt_next = r_cnt + c_cnt_one;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Outputs depend on state only, keeping prod_vld and acc_ack off any
    // combinational path to the ports.
    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_xfer       = 1'b0;
        prod_rdy     = 1'b0;
        acc_vld      = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = (len != '0) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                prod_rdy = 1'b1;
                busy     = 1'b1;
                if (prod_vld) begin
                    w_xfer = 1'b1;
                    if (w_cnt_next == r_len) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                acc_vld = 1'b1;
                busy    = 1'b1;
                if (acc_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (w_start_acc) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_len <= len;
            r_ovf <= 1'b0;
        end else if (w_xfer) begin
            r_acc <= w_acc_sat;
            r_cnt <= w_cnt_next;
            if (w_sat) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign acc_dout = r_acc;
    assign ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_case_7_prod_accum.sv
// ============================================================================
// Module      : tb_case_7_prod_accum
// Description : Scoreboard bench for case_7_prod_accum with a sum/clamp model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_case_7_prod_accum;

    localparam int PW = 15;
    localparam int AW = 16;
    localparam int CW = 8;
    localparam longint ACC_MAX = (longint'(1) << (AW-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (AW-1));

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          start;
    logic [CW-1:0] len;
    logic [PW-1:0] prod_din;
    logic          prod_vld;
    logic          prod_rdy;
    logic [AW-1:0] acc_dout;
    logic          acc_vld;
    logic          acc_ack;
    logic          busy;
    logic          ovf;

    case_7_prod_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .start    (start),
        .len      (len),
        .prod_din (prod_din),
        .prod_vld (prod_vld),
        .prod_rdy (prod_rdy),
        .acc_dout (acc_dout),
        .acc_vld  (acc_vld),
        .acc_ack  (acc_ack),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        longint sum;
        bit     ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: running sum, clamped to the signed result range after each add.
    function automatic exp_t model(input int vals[$]);
        exp_t r;
        r.sum = 0;
        r.ovf = 1'b0;
        foreach (vals[i]) begin
            r.sum = r.sum + longint'(vals[i]);
            if (r.sum > ACC_MAX) begin
                r.sum = ACC_MAX;
                r.ovf = 1'b1;
            end else if (r.sum < ACC_MIN) begin
                r.sum = ACC_MIN;
                r.ovf = 1'b1;
            end
        end
        return r;
    endfunction

    // Monitor: a new result is popped on each rising acc_vld, then every held
    // cycle is compared against it.
    exp_t cur;
    bit   prev_vld = 1'b0;
    always @(negedge ap_clk) begin
        if (ap_rst_n === 1'b1 && acc_vld === 1'b1) begin
            if (!prev_vld) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: acc_vld with nothing pending, acc_dout=%0d",
                             $signed(acc_dout));
                end else begin
                    cur = sb_q.pop_front();
                end
            end
            check("acc_dout", longint'($signed(acc_dout)), cur.sum);
            check("ovf", longint'(ovf), longint'(cur.ovf));
            check("prod_rdy_in_done", longint'(prod_rdy), 0);
            check("busy_in_done", longint'(busy), 1);
        end
        prev_vld = (acc_vld === 1'b1);
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = n[CW-1:0];
        tick();
        start = 1'b0;
        len   = CW'($urandom);
    endtask

    task automatic feed(input int vals[$], input int bubs[$], input bit poke_start);
        foreach (vals[i]) begin
            int v;
            v = vals[i];
            repeat (bubs[i]) begin
                prod_vld = 1'b0;
                prod_din = PW'($urandom);
                start    = poke_start;
                len      = 8'd7;
                tick();
            end
            prod_vld = 1'b1;
            prod_din = v[PW-1:0];
            start    = poke_start;
            len      = 8'd7;
            @(negedge ap_clk);
            check("prod_rdy_accum", longint'(prod_rdy), 1);
            tick();
        end
        prod_vld = 1'b0;
        start    = 1'b0;
    endtask

    task automatic finish_txn(input int ack_delay, input bit with_start, input longint exp_sum);
        @(negedge ap_clk);
        check("acc_vld_latency", longint'(acc_vld), 1);
        tick();
        repeat (ack_delay) tick();
        acc_ack = 1'b1;
        start   = with_start;
        len     = 8'd5;
        tick();
        acc_ack = 1'b0;
        start   = 1'b0;
        @(negedge ap_clk);
        check("acc_vld_after_ack", longint'(acc_vld), 0);
        check("busy_after_ack", longint'(busy), 0);
        check("acc_dout_hold_idle", longint'($signed(acc_dout)), exp_sum);
        if (with_start) begin
            tick();
            @(negedge ap_clk);
            check("start_dropped_with_ack", longint'(busy), 0);
        end
    endtask

    task automatic run_txn(input int vals[$], input int bubs[$], input int ack_delay,
                           input bit poke_start, input bit ack_start);
        exp_t e;
        e = model(vals);
        sb_q.push_back(e);
        do_start(vals.size());
        feed(vals, bubs, poke_start);
        finish_txn(ack_delay, ack_start, e.sum);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[$];
        int bubs[$];

        ap_rst_n = 1'b0;
        start    = 1'b0;
        len      = '0;
        prod_din = '0;
        prod_vld = 1'b0;
        acc_ack  = 1'b0;
        repeat (3) tick();
        @(negedge ap_clk);
        check("rst_acc_dout", longint'($signed(acc_dout)), 0);
        check("rst_acc_vld", longint'(acc_vld), 0);
        check("rst_prod_rdy", longint'(prod_rdy), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_ovf", longint'(ovf), 0);
        tick();
        ap_rst_n = 1'b1;
        tick();

        // Reset in the middle of an accumulation discards the partial sum.
        vals = {10, 20};
        bubs = {0, 0};
        do_start(4);
        feed(vals, bubs, 1'b0);
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("midrst_acc_dout", longint'($signed(acc_dout)), 0);
        check("midrst_acc_vld", longint'(acc_vld), 0);
        check("midrst_prod_rdy", longint'(prod_rdy), 0);
        check("midrst_ovf", longint'(ovf), 0);
        check("midrst_busy", longint'(busy), 0);
        tick();
        vals = {7};        bubs = {0};
        run_txn(vals, bubs, 0, 1'b0, 1'b0);

        vals = {100, -30, 5};        bubs = {0, 0, 0};
        run_txn(vals, bubs, 0, 1'b0, 1'b0);

        vals = {-16384, -16384};     bubs = {0, 2};
        run_txn(vals, bubs, 5, 1'b0, 1'b0);

        vals = {16383, 16383, 16383}; bubs = {0, 0, 0};
        run_txn(vals, bubs, 1, 1'b0, 1'b0);
        vals = {-1};                 bubs = {0};
        run_txn(vals, bubs, 0, 1'b0, 1'b0);

        // len=0 goes straight to DONE and must ignore the offered product.
        begin
            exp_t z;
            z.sum = 0;
            z.ovf = 1'b0;
            sb_q.push_back(z);
            prod_vld = 1'b1;
            prod_din = 15'd99;
            do_start(0);
            finish_txn(2, 1'b0, 0);
            prod_vld = 1'b0;
        end

        vals = {11, 22};             bubs = {1, 0};
        run_txn(vals, bubs, 0, 1'b1, 1'b1);

        vals = {};
        bubs = {};
        for (int i = 0; i < 255; i++) begin
            vals.push_back(1);
            bubs.push_back(0);
        end
        run_txn(vals, bubs, 0, 1'b0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            int n;
            n = int'($urandom_range(12, 1));
            vals = {};
            bubs = {};
            for (int i = 0; i < n; i++) begin
                vals.push_back(int'($urandom_range(32767, 0)) - 16384);
                bubs.push_back(int'($urandom_range(2, 0)));
            end
            run_txn(vals, bubs, int'($urandom_range(3, 0)), 1'(t % 3 == 0), 1'(t % 4 == 1));
        end

        tick();
        check("scoreboard_empty", longint'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/case_7_prod_accum.md
Name: case_7_prod_accum

Overview:
Downstream consumer of the case_7 signed multiplier core. Accepts a stream of signed 15-bit products over a valid/ready handshake and sums a programmed number of them into a saturating signed accumulator. It then presents the registered sum until it is acknowledged. Together with the multiplier it forms the MAC datapath of the case_7 kernel.

Parameters:
PROD_WIDTH, 15, signed product width; matches multiplier dout.
ACC_WIDTH, 24, signed accumulator/result width; must be greater than PROD_WIDTH.
CNT_WIDTH, 8, width of the transaction length field and the internal product counter.

Ports:
ap_clk  input  1  single clock; all logic is rising-edge.
ap_rst_n  input  1  synchronous, active-low reset.
start  input  1  1-cycle request to begin a transaction; sampled only in IDLE.
len  input  CNT_WIDTH  number of products to accumulate; unsigned; captured with start.
prod_din  input  PROD_WIDTH  signed product from the multiplier.
prod_vld  input  1  prod_din is valid.
prod_rdy  output  1  block accepts prod_din this cycle.
acc_dout  output  ACC_WIDTH  signed accumulated result.
acc_vld  output  1  acc_dout is valid; held until acknowledged.
acc_ack  input  1  consumer takes the result.
busy  output  1  high in ACCUM and DONE.
ovf  output  1  sticky saturation flag for the current transaction.

Behaviour:
- Reset (ap_rst_n=0 at a rising edge), also when asserted mid-transaction:
  - state=IDLE; acc register, counter and captured len are all 0.
  - prod_rdy=0, acc_vld=0, busy=0, ovf=0, acc_dout=0.
  - A partial sum is discarded.
- States: IDLE, ACCUM, DONE. Encoding is free.
- IDLE:
  - start=1 captures len, clears the accumulator, counter and ovf.
  - Next state is ACCUM if len != 0, otherwise DONE with result 0.
  - start=0 keeps the block in IDLE.
- ACCUM:
  - prod_rdy=1, driven combinationally from state only; it never depends on prod_vld.
  - A transfer occurs when prod_vld && prod_rdy.
  - On each transfer: acc <= sat(acc + sext(prod_din)); cnt <= cnt+1.
  - The transfer that makes cnt reach len moves the state to DONE at the same edge.
  - No transfer means no change; prod_vld bubbles of any length are allowed.
- DONE:
  - prod_rdy=0, acc_vld=1, and acc_dout is stable.
  - acc_ack=1 returns the state to IDLE at the next edge, with acc_vld=0 in that cycle.
  - acc_dout holds its last value in IDLE until the next start clears it.
- Latency: last product accepted at edge t, acc_vld=1 in the cycle after t. With a continuous prod_vld, a len-N transaction takes N cycles in ACCUM plus 1 cycle minimum in DONE.
- Arithmetic:
  - prod_din is sign-extended to ACC_WIDTH+1 and summed with acc in ACC_WIDTH+1 bits.
  - A sum above 2^(ACC_WIDTH-1)-1 clamps to the maximum; a sum below -2^(ACC_WIDTH-1) clamps to the minimum.
  - Either clamp sets ovf=1, which stays set until the next accepted start or reset.
  - Accumulation continues from the clamped value.
- start while busy=1 is ignored; len is not re-captured.
- start and acc_ack in the same DONE cycle: only acc_ack acts, the state goes to IDLE and start is dropped.
- len = 2^CNT_WIDTH-1 (255) must complete without counter wrap.
- busy=1 exactly when state is ACCUM or DONE.
- No combinational path from acc_ack or prod_vld to any output.

Test Plan:
- Reset mid-ACCUM: len=4, 2 products accepted, ap_rst_n=0 for 1 cycle -> state IDLE, acc_dout=0, acc_vld=0, prod_rdy=0, ovf=0. A fresh start with len=1 and prod_din=7 gives acc_dout=7.
- Basic sum: len=3, prod_din=100, -30, 5 on consecutive cycles with prod_vld=1 -> acc_vld=1 exactly 1 cycle after the third transfer; acc_dout=75, ovf=0. acc_ack=1 -> IDLE the next cycle.
- Bubbles and backpressure: len=2, prod_vld pattern 1,0,0,1 with values -16384, -16384 -> acc_dout=-32768. acc_ack held low 5 cycles -> acc_vld and acc_dout stable throughout, prod_rdy=0.
- Saturation (ACC_WIDTH=16): len=3, prod_din=16383 x3 -> acc_dout=32767, ovf=1. Next start with len=1 and prod_din=-1 -> ovf cleared at start, result -1, ovf=0.
- len=0 and ignored start: start with len=0 -> DONE the next cycle, acc_dout=0, no product accepted even with prod_vld=1. start pulses during ACCUM with len=2 change nothing; exactly 2 products are summed.
- Max length: len=255, prod_din=1 continuous -> acc_dout=255, with acc_vld rising 255 cycles after the first transfer cycle.
